taillight_seq: RTL and testbench
================================

Name: taillight_seq

Overview:
Parametrised sequential turn-signal controller; successor to the fixed 3-lamp left/right taillight FSM. Drives N_LAMPS per side with a thermometer "walking" pattern, adds hazard mode and a programmable step rate. Sits between the driver-input debounce stage and the lamp drivers.

Parameters:
N_LAMPS, 3, lamps per side (>=2); bit 0 is the innermost lamp (la/ra position).
TICK_DIV, 1, clock cycles per pattern step (>=1); 1 means one step per clock.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
left  input  1  left turn request, level.
right  input  1  right turn request, level.
hazard  input  1  hazard request, level.
l_lamps  output  N_LAMPS  left lamps; bit0 innermost (la), bit N_LAMPS-1 outermost (lc).
r_lamps  output  N_LAMPS  right lamps; bit0 innermost (ra), bit N_LAMPS-1 outermost (rc).
active  output  1  high whenever mode != IDLE.

Behaviour:
- Reset (reset=0): asynchronous; mode=IDLE, step=0, prescaler=0, all outputs 0 immediately, held until release.
- Mode decode, each clock, priority: hazard, or (left & right) -> HAZARD; else left -> LEFT; else right -> RIGHT; else IDLE.
- States: IDLE, LEFT, RIGHT, HAZARD. Registered outputs; all lamps are flops.
- Entry or mode change (requested mode != current mode): on that edge, mode is updated, step=1, prescaler=0; the first pattern is visible right after that edge (1-cycle latency from the sampled request).
- Tick: the prescaler counts 0..TICK_DIV-1. The step advances when the prescaler equals TICK_DIV-1 and the mode is unchanged. With TICK_DIV=1, the step advances every clock.
- LEFT: l_lamps = thermometer of step (step k lights bits 0..k-1); r_lamps=0. Step sequence 1,2,..,N_LAMPS,1,... The wrap from N_LAMPS goes to 1; there is no all-off phase.
- RIGHT: mirror of LEFT on r_lamps; l_lamps=0.
- HAZARD: step alternates 1,0,1,0 per tick. Step 1 sets both sides all-ones; step 0 sets both sides all-zeros.
- IDLE: both sides 0. Release of a request returns to IDLE on the next edge, regardless of prescaler phase.
- Direct switch LEFT<->RIGHT: the new side starts at step 1 on the next edge; the old side is 0 on that same edge. No IDLE cycle in between.
- Widths: step counter is $clog2(N_LAMPS+1) bits. Prescaler is $clog2(TICK_DIV) bits (minimum 1). No overflow beyond N_LAMPS or TICK_DIV-1 is possible.

Optional Feature:
Macro TAILLIGHT_BRAKE_EN.
- Defined: adds an input `brake` (1 bit).
  - In IDLE with brake=1: both sides all-ones.
  - In LEFT: r_lamps all-ones while brake=1. In RIGHT: l_lamps all-ones while brake=1.
  - The signalling side keeps its sequence.
  - HAZARD ignores brake.
  - Brake is not a mode: it does not reset step or prescaler, and its effect is registered with 1-cycle latency.
- Undefined: no brake port; behaviour exactly as above.

Decomposition:
- Package taillight_pkg: typedef enum logic [1:0] mode_t {IDLE, LEFT, RIGHT, HAZARD}; function therm(step) returning the N_LAMPS thermometer pattern.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, reset, clr, tick) holds the prescaler. clr is driven on mode change.
- taillight_seq holds the mode/step FSM and the output registers.

Test Plan:
- Reset: N=3, DIV=1, reset=0 mid-sequence -> l_lamps=000, r_lamps=000, active=0 immediately, before any clock edge.
- Left: N=3, DIV=1, left=1 for 6 clocks -> l_lamps 001,011,111,001,011,111; r_lamps=000. Drop left -> 000 on the next edge.
- Right with switch: right=1 for 2 clocks (r=001,011), then left=1/right=0 -> next edge l=001, r=000.
- Hazard: hazard=1 with left=1, 4 clocks -> both sides 111,000,111,000. Then set left=1/right=1 with hazard=0 -> stays HAZARD, no step restart.
- Prescale: N=4, DIV=3, left=1 -> l_lamps 0001 for 3 cycles, then 0011 x3, 0111 x3, 1111 x3, then 0001.
- Brake (TAILLIGHT_BRAKE_EN): IDLE brake=1 -> 111/111 after 1 edge. LEFT with brake=1 -> r=111 while l walks 001,011,111. HAZARD with brake=1 -> pattern unchanged.

Source files
------------

// File: rtl/taillight_pkg.sv
// Shared types and helpers for the taillight sequencer.
// Macro TAILLIGHT_BRAKE_EN (used by taillight_seq) adds a brake input.
package taillight_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_t;

  // Widest lamp bank the thermometer helper can describe; callers truncate.
  localparam int THERM_W = 32;

  // Thermometer code: step k lights bits 0..k-1.
  function automatic logic [THERM_W-1:0] therm(input int step);
    logic [THERM_W-1:0] pat;
    pat = '0;
    for (int i = 0; i < THERM_W; i++) begin
      if (i < step) pat[i] = 1'b1;
    end
    return pat;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Step-rate prescaler: pulses tick once every TICK_DIV clocks, restarts on clr.
module tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == PW'(TICK_DIV - 1));

  // Next prescaler value: restart on mode change or at terminal count.
  always_comb begin
    if (clr || tick) cnt_d = '0;
    else             cnt_d = cnt_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/taillight_seq.sv
// Sequential turn-signal controller: walking thermometer per side, hazard
// flash, programmable step rate via tick_gen.
// Optional macro TAILLIGHT_BRAKE_EN adds a brake input that lights the
// non-signalling side (or both sides in IDLE); HAZARD ignores it.
module taillight_seq
  import taillight_pkg::*;
#(
  parameter int N_LAMPS  = 3,
  parameter int TICK_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  input  logic               hazard,
`ifdef TAILLIGHT_BRAKE_EN
  input  logic               brake,
`endif
  output logic [N_LAMPS-1:0] l_lamps,
  output logic [N_LAMPS-1:0] r_lamps,
  output logic               active
);

  localparam int SW = $clog2(N_LAMPS + 1);
  localparam logic [N_LAMPS-1:0] ONES = '1;

  mode_t              mode_q, mode_d, req;
  logic [SW-1:0]      step_q, step_d;
  logic [N_LAMPS-1:0] l_q, l_d, r_q, r_d, pat;
  logic               active_q, active_d;
  logic               tick, clr, brk;

`ifdef TAILLIGHT_BRAKE_EN
  assign brk = brake;
`else
  assign brk = 1'b0;
`endif

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  // Requested mode; both turn levels together count as hazard.
  always_comb begin
    if (hazard || (left && right)) req = HAZARD;
    else if (left)                 req = LEFT;
    else if (right)                req = RIGHT;
    else                           req = IDLE;
  end

  assign clr = (req != mode_q);

  // Mode/step next state; a mode change restarts the walk at step 1.
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    if (clr) begin
      mode_d = req;
      step_d = SW'(1);
    end else if (tick) begin
      case (mode_q)
        LEFT, RIGHT: step_d = (step_q == SW'(N_LAMPS)) ? SW'(1) : step_q + SW'(1);
        HAZARD:      step_d = (step_q == '0) ? SW'(1) : '0;
        default:     step_d = step_q;
      endcase
    end
  end

  // Lamp patterns derived from the next state so they appear on the same edge.
  always_comb begin
    pat      = N_LAMPS'(therm(int'(step_d)));
    l_d      = '0;
    r_d      = '0;
    active_d = (mode_d != IDLE);
    case (mode_d)
      LEFT: begin
        l_d = pat;
        r_d = brk ? ONES : '0;
      end
      RIGHT: begin
        r_d = pat;
        l_d = brk ? ONES : '0;
      end
      HAZARD: begin
        l_d = (step_d != '0) ? ONES : '0;
        r_d = (step_d != '0) ? ONES : '0;
      end
      default: begin
        l_d = brk ? ONES : '0;
        r_d = brk ? ONES : '0;
      end
    endcase
  end

  // FSM state and registered lamp outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= IDLE;
      step_q   <= '0;
      l_q      <= '0;
      r_q      <= '0;
      active_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      step_q   <= step_d;
      l_q      <= l_d;
      r_q      <= r_d;
      active_q <= active_d;
    end
  end

  assign l_lamps = l_q;
  assign r_lamps = r_q;
  assign active  = active_q;

endmodule

// File: tb/tb_taillight_seq.sv
// Scoreboard bench for taillight_seq: two instances (N=3/DIV=1, N=4/DIV=3)
// share stimulus; a behavioural model pushes expectations each edge and a
// monitor pops and compares them just after the edge.
module tb_taillight_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] l3, r3;
  logic       a3;
  logic [3:0] l4, r4;
  logic       a4;

  int errors = 0;
  int checks = 0;

`ifdef TAILLIGHT_BRAKE_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  taillight_seq #(.N_LAMPS(3), .TICK_DIV(1)) dut_a (
    .clk     (clk),
    .reset   (rst_n),
    .left    (left),
    .right   (right),
    .hazard  (hazard),
`ifdef TAILLIGHT_BRAKE_EN
    .brake   (brake),
`endif
    .l_lamps (l3),
    .r_lamps (r3),
    .active  (a3)
  );

  taillight_seq #(.N_LAMPS(4), .TICK_DIV(3)) dut_b (
    .clk     (clk),
    .reset   (rst_n),
    .left    (left),
    .right   (right),
    .hazard  (hazard),
`ifdef TAILLIGHT_BRAKE_EN
    .brake   (brake),
`endif
    .l_lamps (l4),
    .r_lamps (r4),
    .active  (a4)
  );

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
    logic       a;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Model modes: 0 idle, 1 left, 2 right, 3 hazard.
  int mode_a = 0, cyc_a = 0, mode_b = 0, cyc_b = 0;

  function automatic int decode(logic l, logic r, logic h);
    if (h || (l && r)) return 3;
    if (l) return 1;
    if (r) return 2;
    return 0;
  endfunction

  // Pattern after c edges spent in a mode: the step index is c / div.
  function automatic exp_t model(int mode, int c, int n, int div, logic b);
    exp_t e;
    int idx;
    logic [7:0] all;
    idx = c / div;
    all = (8'd1 << n) - 8'd1;
    e.l = 8'd0;
    e.r = 8'd0;
    e.a = (mode != 0);
    case (mode)
      1: begin
        e.l = (8'd1 << ((idx % n) + 1)) - 8'd1;
        e.r = b ? all : 8'd0;
      end
      2: begin
        e.r = (8'd1 << ((idx % n) + 1)) - 8'd1;
        e.l = b ? all : 8'd0;
      end
      3: begin
        e.l = ((idx % 2) == 0) ? all : 8'd0;
        e.r = e.l;
      end
      default: begin
        e.l = b ? all : 8'd0;
        e.r = e.l;
      end
    endcase
    return e;
  endfunction

  // Reference model: advances on every edge from the inputs the DUT samples.
  always @(posedge clk) begin
    exp_t zero;
    int req;
    logic b;
    zero.l = 8'd0;
    zero.r = 8'd0;
    zero.a = 1'b0;
    b = BRK_EN && brake;
    if (!rst_n) begin
      mode_a = 0; cyc_a = 0;
      mode_b = 0; cyc_b = 0;
      qa.push_back(zero);
      qb.push_back(zero);
    end else begin
      req = decode(left, right, hazard);
      if (req != mode_a) begin mode_a = req; cyc_a = 0; end
      else cyc_a++;
      if (req != mode_b) begin mode_b = req; cyc_b = 0; end
      else cyc_b++;
      qa.push_back(model(mode_a, cyc_a, 3, 1, b));
      qb.push_back(model(mode_b, cyc_b, 4, 3, b));
    end
  end

  // Monitor: compare each instance just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    checks++;
    if (qa.size() == 0) begin
      errors++;
      $display("FAIL dut_a_queue: no expectation at %0t", $time);
    end else begin
      e = qa.pop_front();
      if ({l3, r3, a3} !== {e.l[2:0], e.r[2:0], e.a}) begin
        errors++;
        $display("FAIL dut_a_lamps @%0t: got l=%b r=%b a=%b want l=%b r=%b a=%b",
                 $time, l3, r3, a3, e.l[2:0], e.r[2:0], e.a);
      end
    end
    checks++;
    if (qb.size() == 0) begin
      errors++;
      $display("FAIL dut_b_queue: no expectation at %0t", $time);
    end else begin
      e = qb.pop_front();
      if ({l4, r4, a4} !== {e.l[3:0], e.r[3:0], e.a}) begin
        errors++;
        $display("FAIL dut_b_lamps @%0t: got l=%b r=%b a=%b want l=%b r=%b a=%b",
                 $time, l4, r4, a4, e.l[3:0], e.r[3:0], e.a);
      end
    end
  end

  task automatic run(input logic l, input logic r, input logic h, input logic b, input int n);
    left = l; right = r; hazard = h; brake = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_async_reset(input string name);
    checks++;
    if ({l3, r3, a3, l4, r4, a4} !== 15'd0) begin
      errors++;
      $display("FAIL %s: got a=%b/%b/%b b=%b/%b/%b want all zero",
               name, l3, r3, a3, l4, r4, a4);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_async_reset("reset_initial");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(1, 0, 0, 0, 6);   // left walk
    run(0, 0, 0, 0, 2);   // release
    run(0, 1, 0, 0, 2);   // right
    run(1, 0, 0, 0, 3);   // direct switch to left
    run(0, 0, 0, 0, 1);
    run(1, 0, 1, 0, 4);   // hazard beats left
    run(1, 1, 0, 0, 4);   // left+right stays hazard
    run(0, 0, 0, 0, 2);
    run(1, 0, 0, 0, 14);  // prescaled walk on dut_b incl. wrap
    run(0, 0, 0, 0, 1);
    run(0, 0, 0, 1, 2);   // brake in idle
    run(1, 0, 0, 1, 4);   // brake while left walks
    run(0, 1, 0, 1, 3);   // brake while right walks
    run(0, 0, 1, 1, 3);   // hazard ignores brake
    run(0, 0, 0, 0, 1);

    // Asynchronous reset mid-sequence, between clock edges.
    run(1, 0, 0, 0, 2);
    #2 rst_n = 1'b0;
    #1 check_async_reset("reset_midseq");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 80; i++) begin
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
          $urandom_range(1, 9));
    end
    run(0, 0, 0, 0, 3);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
